// File: rtl/voice_sched.sv
// voice_sched: per-sample sequencer for the shared voice datapath.
// On each accepted sample tick it clears the mixer, runs the oscillator and
// envelope once per voice, accumulates every voice into the mixer, runs the
// filter once and finally flags a finished output sample.
module voice_sched #(
  parameter int NUM_VOICES = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       en_i,
  output logic [1:0] voice_o,
  output logic       osc_start_o,
  input  logic       osc_done_i,
  output logic       env_start_o,
  input  logic       env_done_i,
  output logic       mix_clr_o,
  output logic       mix_acc_o,
  output logic       flt_start_o,
  input  logic       flt_done_i,
  output logic       sample_valid_o,
  output logic       busy_o,
  output logic       overrun_o,
  output logic [9:0] frame_cycles_o
);

  typedef enum logic [3:0] {
    IDLE,
    CLR,
    OSC,
    OSC_WAIT,
    ENV,
    ENV_WAIT,
    MIX,
    FLT,
    FLT_WAIT,
    DONE
  } state_e;

  localparam logic [1:0] LastVoice = 2'(NUM_VOICES - 1);
  localparam logic [9:0] CntMax    = 10'd1023;

  state_e     state_q, state_d;
  logic [1:0] voice_q, voice_d;
  logic [9:0] cnt_q, cnt_d;
  logic [9:0] frameCycles_q, frameCycles_d;
  logic       overrun_q, overrun_d;

  // Next-state logic: frame sequencing, voice index, busy-cycle counter and overrun detect
  always_comb begin
    state_d       = state_q;
    voice_d       = voice_q;
    cnt_d         = cnt_q;
    frameCycles_d = frameCycles_q;
    overrun_d     = tick_i && (state_q != IDLE);

    // cnt_q counts busy cycles including the current one, so DONE sees the full frame length
    if ((state_q != IDLE) && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 10'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick_i && en_i) begin
          state_d = CLR;
          voice_d = '0;
          cnt_d   = 10'd1;
        end
      end
      CLR:      state_d = OSC;
      OSC:      state_d = OSC_WAIT;
      OSC_WAIT: if (osc_done_i) state_d = ENV;
      ENV:      state_d = ENV_WAIT;
      ENV_WAIT: if (env_done_i) state_d = MIX;
      MIX: begin
        if (voice_q == LastVoice) begin
          state_d = FLT;
        end else begin
          voice_d = voice_q + 2'd1;
          state_d = OSC;
        end
      end
      FLT:      state_d = FLT_WAIT;
      FLT_WAIT: if (flt_done_i) state_d = DONE;
      DONE: begin
        frameCycles_d = cnt_q;
        state_d       = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      voice_q       <= '0;
      cnt_q         <= '0;
      frameCycles_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      voice_q       <= voice_d;
      cnt_q         <= cnt_d;
      frameCycles_q <= frameCycles_d;
      overrun_q     <= overrun_d;
    end
  end

  assign voice_o        = voice_q;
  assign mix_clr_o      = (state_q == CLR);
  assign osc_start_o    = (state_q == OSC);
  assign env_start_o    = (state_q == ENV);
  assign mix_acc_o      = (state_q == MIX);
  assign flt_start_o    = (state_q == FLT);
  assign sample_valid_o = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign overrun_o      = overrun_q;
  assign frame_cycles_o = frameCycles_q;

endmodule
